cordic_pipe_reg: RTL
====================

# cordic_pipe_reg

Parametrised elastic pipeline register for the CORDIC datapath: carries `lanes` words of `width` bits through `depth` register stages with a valid/ready handshake, a global freeze code on `sel`, and a synchronous flush. It is the generalised successor of the single-stage CORDIC hold register. It sits between CORDIC rotation stages and the SVD sweep controller, so downstream back-pressure never drops or duplicates a rotation sample.

## Interface
- `width`, 32: bits per lane word.
- `lanes`, 2: parallel words per beat, e.g. x/y pair.
- `depth`, 3: register stages, ≥1.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `sel`  in  4: freeze code; `sel == 0` runs, any non-zero value freezes.
- `flush`  in  1: synchronous clear of all stage valids.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: pipeline accepts a beat this cycle.
- `in_data`  in  `lanes*width`: beat; lane i at bits [i*width +: width].
- `out_valid`  out  1: last stage holds a beat.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  `lanes*width`: last-stage data.
- `count`  out  `$clog2(depth+1)`: number of valid stages.

## Operation
- Per stage k (0..depth-1): registered `v[k]`, data `d[k]`. Stage depth-1 drives the outputs.
- Run condition `run = (sel == 0) && !flush`.
- Advance enables, combinational from the output backward:
  - `adv[depth-1] = run && (!v[depth-1] || out_ready)`
  - `adv[k] = run && (!v[k] || adv[k+1])`
- `in_ready = adv[0]`.
- On `adv[k]`, stage k loads from stage k-1 (input for k=0): `v[k] <= v[k-1]` (`in_valid` for k=0), `d[k] <=` source data.
- Data loads only when the incoming valid is 1. Empty stages keep stale data; data never changes without a valid beat.
- `out_valid = v[depth-1] && (sel == 0)`. When frozen, the output is masked and no beat is consumed.
- `out_data = d[depth-1]` unconditionally.
- Flush: all `v[k] <= 0`. Data registers are untouched. `in_ready` is 0 and `out_valid` still reflects `v[depth-1]` that cycle, but the output beat is discarded even if `out_ready=1`. Upstream must treat the flush cycle as no transfer.
- `count` is the registered population count of `v`, updated every cycle alongside `v`.
- Lanes are independent bit slices. No arithmetic, no per-lane gating.
- No FSM beyond per-stage valid bits. Each stage is either EMPTY (v=0) or FULL (v=1):
  - EMPTY→FULL on `adv[k]` with incoming valid.
  - FULL→EMPTY on `adv[k]` with incoming invalid, or on flush.

## Timing
- Reset, asynchronous on `rst_n` low: all `v=0`, all `d=0`, `count=0`, `out_valid=0`, `out_data=0`, `in_ready=0` while `sel != 0`, otherwise 1.
- First `in_ready` after reset deassertion with `sel=0`: 1 combinationally.
- Latency: a beat accepted at edge N is visible on `out_valid/out_data` after edge N+depth-1, i.e. it is the last-stage contents following depth accepting edges. With no stall and depth=3: accepted at edge 0, out at edge 2 (visible after edge 2).
- Throughput: 1 beat/cycle when `out_ready=1` and `sel=0`.
- Full pipe, `out_ready=0`: `in_ready=0`, and nothing moves.
- Full pipe, `out_ready=1`: simultaneous consume and accept in the same cycle, and `count` stays `depth`.
- Bubbles collapse. Stages advance into empty slots even while the output is stalled, until the pipe is full.
- Freeze (`sel≠0`) is cycle-exact: state holds and the cycle after `sel` returns to 0 behaves as if the frozen cycles never occurred.
- Flush and freeze in the same cycle: flush wins, and the valids clear.
- Reset mid-stream: all beats are lost immediately, with no partial outputs.
- Combinational paths: `out_ready`, `sel`, `flush` → `in_ready` and `out_ready` → `adv` chain. There is no path from `in_valid` to `in_ready`.

## Test plan
- Streaming: width=32, lanes=2, depth=3, sel=0, out_ready=1; drive beats {lane1,lane0} = {i, 0x1000+i}, i=0..15, back to back → outputs appear in order. The first appears after the 3rd accepting edge, then one per cycle, and `count` settles at 3.
- Back-pressure fill: out_ready=0, feed 5 beats → exactly 3 accepted, `in_ready=0` thereafter, `count=3`. Raise out_ready → beats 0,1,2 then 3,4 emerge with no loss or duplication.
- Bubble collapse: inject beats at cycles 0 and 4 with out_ready=0 → `count` goes 1 then 2. Both beats end in stages 2 and 1, and the output order is preserved.
- Freeze: mid-stream set sel=4'h5 for 4 cycles → `in_ready=0`, `out_valid=0`, `count` unchanged. After sel=0 the sequence resumes with no gap or repeat.
- Flush: pipe holding 3 beats, pulse flush with in_valid=1 and out_ready=1 → `count=0` next cycle. The flush-cycle input is not accepted and the next output is the first beat sent after the flush.
- Async reset: assert rst_n=0 mid-stream between clock edges → `out_valid`, `out_data`, and `count` go 0 immediately. After release, a beat with value 0xDEADBEEF_12345678 passes through with latency 3.

Source files
------------

// File: rtl/cordic_pipe_reg.sv
// Elastic multi-stage pipeline register for the CORDIC datapath.
// Valid/ready handshake with global freeze code, synchronous flush and occupancy count.
module cordic_pipe_reg #(
    parameter int unsigned width = 32,
    parameter int unsigned lanes = 2,
    parameter int unsigned depth = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   sel,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [lanes*width-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [lanes*width-1:0]       out_data,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int unsigned cw = $clog2(depth + 1);
    localparam int unsigned dw = lanes * width;

    logic             run;
    logic [depth-1:0] v;
    logic [depth-1:0] v_nxt;
    logic [depth-1:0] adv;
    logic [depth-1:0] src_v;
    logic [dw-1:0]    d     [depth];
    logic [dw-1:0]    src_d [depth];

    function automatic logic [cw-1:0] popcnt(input logic [depth-1:0] x);
        logic [cw-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            c = c + cw'(x[i]);
        end
        return c;
    endfunction

    assign run = (sel == 4'd0) && !flush;

    // adv[k] = run && (!v[k] || adv[k+1]) unrolled as: stage k may move unless
    // every stage from k to the output is full and the output is stalled.
    always_comb begin : adv_chain
        logic tail_full;
        adv       = '0;
        tail_full = 1'b1;
        for (int unsigned i = 0; i < depth; i++) begin
            tail_full          = tail_full & v[depth-1-i];
            adv[depth-1-i]     = run && (out_ready || !tail_full);
        end
    end

    always_comb begin
        v_nxt = v;
        if (flush) begin
            v_nxt = '0;
        end else begin
            for (int unsigned k = 0; k < depth; k++) begin
                if (adv[k]) begin
                    v_nxt[k] = src_v[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            count <= '0;
        end else begin
            v     <= v_nxt;
            count <= popcnt(v_nxt);
        end
    end

    for (genvar k = 0; k < depth; k++) begin : g_stage
        logic [dw-1:0] d_q;

        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_d[k] = in_data;
        end else begin : g_body
            assign src_v[k] = v[k-1];
            assign src_d[k] = d[k-1];
        end

        // Data only moves with a valid beat; empty stages keep stale contents.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
            end else if (adv[k] && src_v[k]) begin
                d_q <= src_d[k];
            end
        end

        assign d[k] = d_q;
    end

    assign in_ready  = adv[0];
    assign out_valid = v[depth-1] && (sel == 4'd0);
    assign out_data  = d[depth-1];

endmodule
